// File: rtl/hsync_rx_buffer.sv
// rtl/hsync_rx_buffer.sv - receive-side 4-phase req/ack handshake with a show-ahead FIFO
//
// Purpose:
//    Destination end of a req/ack clock-domain crossing. req_in is synchronized
//    into clk_r, datain is captured once per request into a small FIFO, and
//    ack_out is returned to the source. While the FIFO is full, ack_out is
//    withheld, which holds the source off. The FIFO is drained through a
//    valid/ready interface.
//
// Ports:
//    clk_r       in   receive-domain clock (only clock)
//    reset_r     in   synchronous active-high reset
//    req_in      in   source request, asynchronous to clk_r
//    datain      in   source data, held stable by the source while req is up
//    ack_out     out  acknowledge to source, straight from a flop
//    dout        out  FIFO head word (show-ahead)
//    dout_valid  out  FIFO non-empty
//    dout_ready  in   consumer takes the head word
//    level       out  FIFO occupancy 0..DEPTH

module hsync_rx_buffer #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk_r,
   input  logic                       reset_r,
   input  logic                       req_in,
   input  logic [DATA_W-1:0]          datain,
   output logic                       ack_out,
   output logic [DATA_W-1:0]          dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_sync;

   logic [0:0]             state_q, state_d;
   logic                   ack_q, ack_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [DATA_W-1:0]      mem_q [DEPTH];

   logic                   full;
   logic                   wr_en;
   logic                   pop;

   // Only the first flop of this chain ever sees req_in, so metastability
   // stays confined there.
   always_ff @(posedge clk_r) begin
      if (reset_r) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      end
   end

   assign req_sync = sync_q[SYNC_STAGES-1];

   // Full is judged on the registered level only: a pop in the same cycle
   // does not open a slot until the following edge.
   assign full  = (level_q == LVL_W'(DEPTH));
   assign wr_en = (state_q == ST_IDLE) && req_sync && !full;
   assign pop   = (level_q != '0) && dout_ready;

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_en) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
            end
         end
         ST_ACK: begin
            // Stay here until the source drops req, so each req high phase
            // produces exactly one write.
            if (!req_sync) begin
               state_d = ST_IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_r) begin
      if (reset_r) begin
         state_q  <= ST_IDLE;
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is intentionally not reset; level gates its visibility.
   always_ff @(posedge clk_r) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= datain;
      end
   end

   always_ff @(posedge clk_r) begin
      if (!reset_r && wr_en) begin
         assert (level_q != LVL_W'(DEPTH));
      end
   end

   assign ack_out    = ack_q;
   assign dout       = mem_q[rd_ptr_q];
   assign dout_valid = (level_q != '0);
   assign level      = level_q;

endmodule

// File: tb/tb_hsync_rx_buffer.sv
// tb/tb_hsync_rx_buffer.sv - directed self-checking bench for hsync_rx_buffer

module tb_hsync_rx_buffer;

   logic       clk_r = 1'b0;
   logic       reset_r;
   logic       req_in;
   logic [7:0] datain;
   logic       ack_out;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic [2:0] level;

   int errors = 0;
   int checks = 0;

   hsync_rx_buffer #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk_r      (clk_r),
      .reset_r    (reset_r),
      .req_in     (req_in),
      .datain     (datain),
      .ack_out    (ack_out),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level)
   );

   always #5 clk_r = ~clk_r;

   // Advance n rising edges, then settle at the falling edge to sample/drive.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_r);
      @(negedge clk_r);
   endtask

   // Full handshake with a bounded wait on each ack transition.
   task automatic xfer(input logic [7:0] d);
      int n;
      datain = d;
      req_in = 1'b1;
      n = 0;
      while (!ack_out && n < 20) begin tick(1); n++; end
      checks++;
      if (ack_out !== 1'b1) begin
         errors++; $display("FAIL xfer_ack_rise data=%h ack=%b want 1", d, ack_out);
      end
      req_in = 1'b0;
      n = 0;
      while (ack_out && n < 20) begin tick(1); n++; end
      checks++;
      if (ack_out !== 1'b0) begin
         errors++; $display("FAIL xfer_ack_fall data=%h ack=%b want 0", d, ack_out);
      end
   endtask

   task automatic test_reset;
      reset_r = 1'b1; req_in = 1'b0; datain = 8'h00; dout_ready = 1'b0;
      tick(3);
      reset_r = 1'b0;
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack ack=%b want 0", ack_out); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid valid=%b want 0", dout_valid); end
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL reset_level level=%0d want 0", level); end
   endtask

   task automatic test_single;
      datain = 8'hA5; req_in = 1'b1;
      tick(2);
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL single_ack_early ack=%b want 0", ack_out); end
      tick(1);
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL single_ack ack=%b want 1", ack_out); end
      checks++;
      if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid valid=%b want 1", dout_valid); end
      checks++;
      if (dout !== 8'hA5) begin errors++; $display("FAIL single_dout dout=%h want a5", dout); end
      checks++;
      if (level !== 3'd1) begin errors++; $display("FAIL single_level level=%0d want 1", level); end
      req_in = 1'b0;
      tick(2);
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL single_ack_hold ack=%b want 1", ack_out); end
      tick(1);
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL single_ack_fall ack=%b want 0", ack_out); end
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level level=%0d want 0", level); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid valid=%b want 0", dout_valid); end
   endtask

   task automatic test_backpressure;
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
      for (int i = 1; i <= 4; i++) xfer(8'(i));
      checks++;
      if (level !== 3'd4) begin errors++; $display("FAIL bp_full_level level=%0d want 4", level); end
      checks++;
      if (dout !== 8'h01) begin errors++; $display("FAIL bp_head dout=%h want 01", dout); end
      datain = 8'h05; req_in = 1'b1;
      tick(6);
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL bp_ack_withheld ack=%b want 0", ack_out); end
      checks++;
      if (level !== 3'd4) begin errors++; $display("FAIL bp_level_held level=%0d want 4", level); end
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      checks++;
      if (dout !== 8'h02) begin errors++; $display("FAIL bp_pop_dout dout=%h want 02", dout); end
      checks++;
      if (level !== 3'd3) begin errors++; $display("FAIL bp_pop_level level=%0d want 3", level); end
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL bp_no_same_edge_write ack=%b want 0", ack_out); end
      tick(1);
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL bp_late_ack ack=%b want 1", ack_out); end
      checks++;
      if (level !== 3'd4) begin errors++; $display("FAIL bp_late_level level=%0d want 4", level); end
      req_in = 1'b0;
      tick(3);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dout !== exp_q[i]) begin errors++; $display("FAIL bp_drain[%0d] dout=%h want %h", i, dout, exp_q[i]); end
         dout_ready = 1'b1;
         tick(1);
         dout_ready = 1'b0;
      end
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL bp_drained level=%0d want 0", level); end
   endtask

   task automatic test_simul;
      xfer(8'h21);
      xfer(8'h22);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      xfer(8'h23);
      checks++;
      if (level !== 3'd2) begin errors++; $display("FAIL simul_pre_level level=%0d want 2", level); end
      datain = 8'h24; req_in = 1'b1;
      tick(2);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL simul_ack ack=%b want 1", ack_out); end
      checks++;
      if (level !== 3'd2) begin errors++; $display("FAIL simul_level level=%0d want 2", level); end
      checks++;
      if (dout !== 8'h23) begin errors++; $display("FAIL simul_dout dout=%h want 23", dout); end
      req_in = 1'b0;
      tick(3);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      checks++;
      if (dout !== 8'h24) begin errors++; $display("FAIL simul_order dout=%h want 24", dout); end
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL simul_drained level=%0d want 0", level); end
   endtask

   task automatic test_wrap;
      int idx = 0;
      int lvl_bad = 0;
      dout_ready = 1'b1;
      for (int w = 0; w < 10; w++) begin
         for (int c = 0; c < 8; c++) begin
            if (c == 0) begin datain = 8'h10 + 8'(w); req_in = 1'b1; end
            if (c == 4) req_in = 1'b0;
            tick(1);
            if (level > 3'd1) lvl_bad++;
            if (dout_valid) begin
               checks++;
               if (idx >= 10 || dout !== 8'h10 + 8'(idx)) begin
                  errors++; $display("FAIL wrap_order[%0d] dout=%h want %h", idx, dout, 8'h10 + 8'(idx));
               end
               idx++;
            end
         end
      end
      dout_ready = 1'b0;
      checks++;
      if (idx != 10) begin errors++; $display("FAIL wrap_count got=%0d want 10", idx); end
      checks++;
      if (lvl_bad != 0) begin errors++; $display("FAIL wrap_level_max over_one=%0d want 0", lvl_bad); end
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL wrap_end_level level=%0d want 0", level); end
   endtask

   task automatic test_hold;
      datain = 8'h77; req_in = 1'b1;
      tick(20);
      checks++;
      if (level !== 3'd1) begin errors++; $display("FAIL hold_level level=%0d want 1", level); end
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL hold_ack ack=%b want 1", ack_out); end
      req_in = 1'b0;
      tick(2);
      checks++;
      if (ack_out !== 1'b1) begin errors++; $display("FAIL hold_ack_until_sync ack=%b want 1", ack_out); end
      tick(1);
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL hold_ack_fall ack=%b want 0", ack_out); end
      checks++;
      if (level !== 3'd1 || dout !== 8'h77) begin
         errors++; $display("FAIL hold_single_capture level=%0d dout=%h want 1/77", level, dout);
      end
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      xfer(8'h31);
      xfer(8'h32);
      datain = 8'h33; req_in = 1'b1;
      tick(3);
      checks++;
      if (ack_out !== 1'b1 || level !== 3'd3) begin
         errors++; $display("FAIL rst_mid_pre ack=%b level=%0d want 1/3", ack_out, level);
      end
      reset_r = 1'b1;
      tick(1);
      reset_r = 1'b0;
      checks++;
      if (ack_out !== 1'b0) begin errors++; $display("FAIL rst_mid_ack ack=%b want 0", ack_out); end
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL rst_mid_level level=%0d want 0", level); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid valid=%b want 0", dout_valid); end
      tick(2);
      checks++;
      if (level !== 3'd0) begin errors++; $display("FAIL rst_mid_early level=%0d want 0", level); end
      tick(1);
      checks++;
      if (level !== 3'd1 || ack_out !== 1'b1 || dout !== 8'h33) begin
         errors++; $display("FAIL rst_mid_recapture level=%0d ack=%b dout=%h want 1/1/33", level, ack_out, dout);
      end
      req_in = 1'b0;
      tick(3);
   endtask

   initial begin
      test_reset;
      test_single;
      test_backpressure;
      test_simul;
      test_wrap;
      test_hold;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
